// File: rtl/fb_access_arbiter.sv
// Round-robin arbiter sharing the framebuffer SRAM GPU port between the rasteriser (req 0)
// and the clear/readback engine (req 1); accesses issue only during blanking and replay on collision.
module fb_access_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic              I_VIDEO_ON,
    input  logic [1:0]        I_REQ_VALID,
    input  logic [1:0]        I_REQ_WE,
    input  logic [ADDR_W-1:0] I_REQ_ADDR0,
    input  logic [ADDR_W-1:0] I_REQ_ADDR1,
    input  logic [DATA_W-1:0] I_REQ_DATA0,
    input  logic [DATA_W-1:0] I_REQ_DATA1,
    output logic [1:0]        O_REQ_READY,
    output logic [DATA_W-1:0] O_RDATA,
    output logic [1:0]        O_RDATA_VALID,
    input  logic [DATA_W-1:0] I_GPU_DATA,
    output logic [ADDR_W-1:0] O_GPU_ADDR,
    output logic [DATA_W-1:0] O_GPU_DATA,
    output logic              O_GPU_READ,
    output logic              O_GPU_WRITE,
    output logic              O_BUSY
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_BLANK} state_t;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rvld_q, rvld_d;
    logic              win;

    // Strobes are registered and set only on entry to ACCESS, so they are high exactly in ACCESS.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rdata_d     = rdata_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        rvld_d      = 2'b00;
        O_REQ_READY = 2'b00;
        win         = I_REQ_VALID[prio_q] ? prio_q : ~prio_q;
        case (state_q)
            IDLE: begin
                if (!I_VIDEO_ON && (|I_REQ_VALID)) begin
                    O_REQ_READY[win] = 1'b1;
                    owner_d          = win;
                    we_d             = I_REQ_WE[win];
                    addr_d           = win ? I_REQ_ADDR1 : I_REQ_ADDR0;
                    data_d           = win ? I_REQ_DATA1 : I_REQ_DATA0;
                    prio_d           = ~win;
                    rd_d             = ~I_REQ_WE[win];
                    wr_d             = I_REQ_WE[win];
                    state_d          = ACCESS;
                end
            end
            ACCESS: begin
                if (!I_VIDEO_ON) begin
                    if (!we_q) begin
                        rdata_d         = I_GPU_DATA;
                        rvld_d[owner_q] = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_BLANK;
                end
            end
            WAIT_BLANK: begin
                if (!I_VIDEO_ON) begin
                    rd_d    = ~we_q;
                    wr_d    = we_q;
                    state_d = ACCESS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            rvld_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
        end
    end

    assign O_GPU_ADDR    = addr_q;
    assign O_GPU_DATA    = data_q;
    assign O_GPU_READ    = rd_q;
    assign O_GPU_WRITE   = wr_q;
    assign O_RDATA       = rdata_q;
    assign O_RDATA_VALID = rvld_q;
    assign O_BUSY        = (state_q != IDLE);

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter: grant timing, read return, round-robin, video collision/gating, reset.
module tb_fb_access_arbiter;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    logic              I_CLK = 1'b0;
    logic              I_RST_N = 1'b0;
    logic              I_VIDEO_ON = 1'b0;
    logic [1:0]        I_REQ_VALID = 2'b00;
    logic [1:0]        I_REQ_WE = 2'b00;
    logic [ADDR_W-1:0] I_REQ_ADDR0 = '0;
    logic [ADDR_W-1:0] I_REQ_ADDR1 = '0;
    logic [DATA_W-1:0] I_REQ_DATA0 = '0;
    logic [DATA_W-1:0] I_REQ_DATA1 = '0;
    logic [1:0]        O_REQ_READY;
    logic [DATA_W-1:0] O_RDATA;
    logic [1:0]        O_RDATA_VALID;
    logic [DATA_W-1:0] I_GPU_DATA = '0;
    logic [ADDR_W-1:0] O_GPU_ADDR;
    logic [DATA_W-1:0] O_GPU_DATA;
    logic              O_GPU_READ;
    logic              O_GPU_WRITE;
    logic              O_BUSY;

    int ncmp = 0;
    int nfail = 0;

    fb_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_VIDEO_ON(I_VIDEO_ON),
        .I_REQ_VALID(I_REQ_VALID), .I_REQ_WE(I_REQ_WE),
        .I_REQ_ADDR0(I_REQ_ADDR0), .I_REQ_ADDR1(I_REQ_ADDR1),
        .I_REQ_DATA0(I_REQ_DATA0), .I_REQ_DATA1(I_REQ_DATA1),
        .O_REQ_READY(O_REQ_READY), .O_RDATA(O_RDATA), .O_RDATA_VALID(O_RDATA_VALID),
        .I_GPU_DATA(I_GPU_DATA), .O_GPU_ADDR(O_GPU_ADDR), .O_GPU_DATA(O_GPU_DATA),
        .O_GPU_READ(O_GPU_READ), .O_GPU_WRITE(O_GPU_WRITE), .O_BUSY(O_BUSY)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_CLK);
        #1;
    endtask

    int grants;
    logic [1:0] exp_gnt;
    int wr_pulses;

    initial begin
        // reset state
        #12;
        chk("rst_ready", {30'd0, O_REQ_READY}, 0);
        chk("rst_strobes", {30'd0, O_GPU_READ, O_GPU_WRITE}, 0);
        chk("rst_busy", {31'd0, O_BUSY}, 0);
        chk("rst_addr", {14'd0, O_GPU_ADDR}, 0);
        chk("rst_rdata", {16'd0, O_RDATA}, 0);
        chk("rst_rvld", {30'd0, O_RDATA_VALID}, 0);
        I_RST_N = 1'b1;
        tick();

        // single write from req0
        I_REQ_VALID = 2'b01; I_REQ_WE = 2'b01;
        I_REQ_ADDR0 = 18'h00123; I_REQ_DATA0 = 16'h0F0F;
        #1;
        chk("wr_ready", {30'd0, O_REQ_READY}, 32'h1);
        tick();
        I_REQ_VALID = 2'b00;
        chk("wr_strobe", {30'd0, O_GPU_READ, O_GPU_WRITE}, 32'h1);
        chk("wr_addr", {14'd0, O_GPU_ADDR}, 32'h00123);
        chk("wr_data", {16'd0, O_GPU_DATA}, 32'h0F0F);
        chk("wr_busy", {31'd0, O_BUSY}, 1);
        tick();
        chk("wr_done_strobe", {30'd0, O_GPU_READ, O_GPU_WRITE}, 0);
        chk("wr_done_rvld", {30'd0, O_RDATA_VALID}, 0);
        chk("wr_done_busy", {31'd0, O_BUSY}, 0);

        // read from req1 at top address
        I_REQ_VALID = 2'b10; I_REQ_WE = 2'b00; I_REQ_ADDR1 = 18'h3FFFF;
        I_GPU_DATA = 16'hABCD;
        #1;
        chk("rd_ready", {30'd0, O_REQ_READY}, 32'h2);
        tick();
        I_REQ_VALID = 2'b00;
        chk("rd_strobe", {30'd0, O_GPU_READ, O_GPU_WRITE}, 32'h2);
        chk("rd_addr", {14'd0, O_GPU_ADDR}, 32'h3FFFF);
        tick();
        I_GPU_DATA = 16'h1111;
        chk("rd_rdata", {16'd0, O_RDATA}, 32'hABCD);
        chk("rd_rvld", {30'd0, O_RDATA_VALID}, 32'h2);
        chk("rd_strobe_off", {30'd0, O_GPU_READ, O_GPU_WRITE}, 0);
        tick();
        chk("rd_rvld_pulse", {30'd0, O_RDATA_VALID}, 0);
        chk("rd_rdata_hold", {16'd0, O_RDATA}, 32'hABCD);

        // contention: both valid, pointer back at req0
        I_REQ_VALID = 2'b11; I_REQ_WE = 2'b11;
        I_REQ_ADDR0 = 18'h00A00; I_REQ_ADDR1 = 18'h00B00;
        grants = 0;
        exp_gnt = 2'b01;
        for (int cyc = 0; cyc < 40 && grants < 8; cyc++) begin
            #1;
            chk("cont_not_both", {31'd0, O_REQ_READY == 2'b11}, 0);
            if (O_REQ_READY != 2'b00) begin
                chk("cont_order", {30'd0, O_REQ_READY}, {30'd0, exp_gnt});
                exp_gnt = ~exp_gnt;
                grants++;
            end
            tick();
        end
        chk("cont_grants", grants, 8);
        I_REQ_VALID = 2'b00;
        tick();
        chk("cont_idle", {31'd0, O_BUSY}, 0);

        // video collision on a write to 0x00010
        I_REQ_VALID = 2'b01; I_REQ_WE = 2'b01;
        I_REQ_ADDR0 = 18'h00010; I_REQ_DATA0 = 16'h1234;
        #1;
        chk("col_ready", {30'd0, O_REQ_READY}, 32'h1);
        tick();
        I_REQ_VALID = 2'b00;
        I_VIDEO_ON = 1'b1;
        chk("col_first_wr", {31'd0, O_GPU_WRITE}, 1);
        wr_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("col_hold_wr", {30'd0, O_GPU_READ, O_GPU_WRITE}, 0);
            chk("col_hold_busy", {31'd0, O_BUSY}, 1);
            chk("col_hold_rvld", {30'd0, O_RDATA_VALID}, 0);
        end
        I_VIDEO_ON = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (O_GPU_WRITE) begin
                wr_pulses++;
                chk("col_replay_addr", {14'd0, O_GPU_ADDR}, 32'h00010);
                chk("col_replay_data", {16'd0, O_GPU_DATA}, 32'h1234);
            end
        end
        chk("col_replay_once", wr_pulses, 1);
        chk("col_idle", {31'd0, O_BUSY}, 0);

        // video gating: req0 waits 100 cycles of active video
        I_VIDEO_ON = 1'b1;
        I_REQ_VALID = 2'b01; I_REQ_WE = 2'b01; I_REQ_ADDR0 = 18'h00055;
        for (int i = 0; i < 100; i++) begin
            #1;
            chk("gate_ready", {30'd0, O_REQ_READY}, 0);
            chk("gate_strobes", {30'd0, O_GPU_READ, O_GPU_WRITE}, 0);
            tick();
        end
        I_VIDEO_ON = 1'b0;
        #1;
        chk("gate_grant", {30'd0, O_REQ_READY}, 32'h1);
        tick();
        I_REQ_VALID = 2'b00;
        chk("gate_wr", {31'd0, O_GPU_WRITE}, 1);
        chk("gate_addr", {14'd0, O_GPU_ADDR}, 32'h00055);
        tick();

        // reset during a read ACCESS
        I_REQ_VALID = 2'b10; I_REQ_WE = 2'b00; I_REQ_ADDR1 = 18'h00200;
        #1;
        chk("rst_mid_ready", {30'd0, O_REQ_READY}, 32'h2);
        tick();
        I_REQ_VALID = 2'b00;
        chk("rst_mid_rd", {31'd0, O_GPU_READ}, 1);
        I_RST_N = 1'b0;
        #1;
        chk("rst_mid_strobes", {30'd0, O_GPU_READ, O_GPU_WRITE}, 0);
        chk("rst_mid_busy", {31'd0, O_BUSY}, 0);
        tick();
        I_RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_norepl_strobes", {30'd0, O_GPU_READ, O_GPU_WRITE}, 0);
            chk("rst_norepl_busy", {31'd0, O_BUSY}, 0);
            chk("rst_norepl_rvld", {30'd0, O_RDATA_VALID}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
